cam_capture_ov7670: RTL
=======================

Name: cam_capture_ov7670

Overview:
- Upstream write-side stage of the frame buffer. Captures an OV7670-style 8-bit parallel pixel stream (RGB565, two bytes per pixel) clocked by the camera pixel clock.
- Converts each pixel to RGB555 and drives the frame buffer's write port: address, data and a one-cycle write strobe, one write per pixel.
- Crops the incoming frame to IMG_W x IMG_H and emits a frame-done pulse for downstream control logic.

Parameters:
AW, 13, frame-buffer address width; must satisfy IMG_W*IMG_H <= 2**AW
DW, 15, pixel word width written to the buffer (RGB555)
IMG_W, 80, pixels stored per line
IMG_H, 60, lines stored per frame

Ports:
clk  in  1  camera pixel clock (PCLK); only clock
rst  in  1  asynchronous, active-low reset
cap_en  in  1  capture enable; sampled at frame start
vsync  in  1  camera VSYNC; high = vertical blanking
href  in  1  camera HREF; high = valid line bytes
px_data  in  8  camera data byte
mem_addr  out  AW  buffer write address
mem_data  out  DW  buffer write data, {R[4:0],G[4:0],B[4:0]}
mem_wr  out  1  write strobe, one cycle per pixel
frame_done  out  1  one-cycle pulse at end of a captured frame
busy  out  1  high while a frame is being captured

Behaviour:
- Reset (rst=0, async): state=WAIT_VS, mem_addr=0, mem_data=0, mem_wr=0, frame_done=0, busy=0; all counters cleared. Release is synchronous to clk.
- All camera inputs are sampled on the rising edge of clk. vsync and href edges are detected against a one-cycle registered copy of each.
- FSM states:
  - WAIT_VS: wait for a vsync falling edge.
    - On the edge with cap_en=1: go to CAPTURE, busy=1, row=0, col=0, line_base=0, byte phase=HI.
    - On the edge with cap_en=0: stay in WAIT_VS.
  - CAPTURE, pixel assembly:
    - With href=1, byte phase alternates HI/LO. The HI byte is stored as {R5,G[5:3]}.
    - On the LO byte, the pixel assembles to R=hi[7:3], G={hi[2:0],lo[7:6]} (G6 LSB lo[5] dropped), B=lo[4:0].
  - CAPTURE, write:
    - If row<IMG_H and col<IMG_W: on the edge sampling the LO byte, register mem_data, mem_addr=line_base+col, mem_wr=1. The strobe is high for exactly the following cycle.
    - col increments after every LO byte and saturates at IMG_W. Pixels with col>=IMG_W are dropped, with no write.
  - CAPTURE, line end:
    - On an href falling edge: col=0, byte phase=HI (an odd trailing HI byte is discarded), row+=1 (saturates at IMG_H).
    - line_base+=IMG_W only while row<IMG_H.
    - Rows >= IMG_H produce no writes.
  - CAPTURE, frame end: on a vsync rising edge, frame_done=1 for one cycle, busy=0, go to WAIT_VS.
- mem_wr is never high on two consecutive cycles; mem_addr and mem_data hold their last values while mem_wr=0.
- Address arithmetic is in AW bits with no wrap. The parameter constraint guarantees the maximum address IMG_W*IMG_H-1 fits.
- vsync rising mid-line aborts the frame: any partial pixel is discarded and frame_done still pulses. Pixels already written remain in the buffer.
- href high while in WAIT_VS (or vsync=1): ignored, no writes.
- cap_en changes mid-frame: no effect until the next vsync falling edge.
- Reset mid-frame: outputs clear immediately. Capture resumes only at the next full frame start (vsync falling), never mid-frame.
- A simultaneous href falling edge and vsync rising edge is handled as frame end.

Test Plan:
- Reset then a 2x2 frame (IMG_W=2, IMG_H=2), bytes 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F / 0xFF,0xFF -> writes addr0=0x7C00, addr1=0x03E0, addr2=0x001F, addr3=0x7FFF. Each mem_wr is one cycle, on the cycle after the LO byte; frame_done pulses once on vsync rise.
- Line of 100 pixels with IMG_W=80 -> exactly 80 writes, addresses line_base..line_base+79; pixels 80..99 produce no mem_wr.
- 70 lines with IMG_H=60 -> the last write is at address 4799; lines 61-70 produce no writes; busy falls at the vsync rise.
- Line with an odd byte count (5 bytes) -> 2 writes; the next line restarts at HI phase with col=0 and address line_base+IMG_W.
- cap_en=0 at the vsync fall -> zero writes for the whole frame, no frame_done. Raise cap_en mid-frame -> still zero writes until the next frame.
- Assert rst mid-line -> mem_wr=0, busy=0 at once. After release, href data is ignored until the next vsync fall; the first write after that is at addr 0.

Source files
------------

// File: rtl/cam_capture_ov7670.sv
// rtl/cam_capture_ov7670.sv - OV7670 RGB565 byte stream to RGB555 frame-buffer writes
// Crops to IMG_W x IMG_H, one write strobe per stored pixel, frame_done on VSYNC rise.
module cam_capture_ov7670 #(
  parameter int AW    = 13,
  parameter int DW    = 15,
  parameter int IMG_W = 80,
  parameter int IMG_H = 60
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  output logic          frame_done,
  output logic          busy
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H);
  localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);

  typedef enum logic {WAIT_VS, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic          vsync_q, href_q;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_wr_q, mem_wr_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  logic          vs_fall, vs_rise, href_fall;
  logic [5:0]    g6;

  assign vs_fall   = vsync_q & ~vsync;
  assign vs_rise   = ~vsync_q & vsync;
  assign href_fall = href_q & ~href;
  // Six-bit green; its LSB is dropped by the shift below.
  assign g6        = {hi_q[2:0], px_data[7:5]};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    col_d        = col_q;
    row_d        = row_q;
    line_base_d  = line_base_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_wr_d     = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      WAIT_VS: begin
        if (vs_fall && cap_en) begin
          state_d     = CAPTURE;
          busy_d      = 1'b1;
          row_d       = '0;
          col_d       = '0;
          line_base_d = '0;
          phase_d     = 1'b0;
        end
      end
      CAPTURE: begin
        // Frame end wins over a coincident line end and drops any half pixel.
        if (vs_rise) begin
          state_d      = WAIT_VS;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else if (href_fall) begin
          col_d   = '0;
          phase_d = 1'b0;
          if (row_q < ROW_MAX) begin
            row_d       = row_q + RW'(1);
            line_base_d = line_base_q + LINE_STEP;
          end
        end else if (href) begin
          if (!phase_q) begin
            hi_d    = px_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (row_q < ROW_MAX && col_q < COL_MAX) begin
              mem_wr_d   = 1'b1;
              mem_addr_d = line_base_q + AW'(col_q);
              mem_data_d = DW'({hi_q[7:3], 5'(g6 >> 1), px_data[4:0]});
            end
            if (col_q < COL_MAX) col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_VS;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      line_base_q  <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wr_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      href_q       <= href;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_base_q  <= line_base_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wr_q     <= mem_wr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wr     = mem_wr_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
